// File: rtl/l2_dbg_pkg.sv
// Shared definitions for the L2 debug trace arbiter.
// Optional feature macro: L2_DBG_TRACE_TS_EN (per-entry capture timestamps).
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 64
`endif

package l2_dbg_pkg;

    localparam logic [1:0] CH_NONE = 2'd0;
    localparam logic [1:0] CH_NOC1 = 2'd1;
    localparam logic [1:0] CH_NOC2 = 2'd2;
    localparam logic [1:0] CH_NOC3 = 2'd3;

    localparam int unsigned TS_W = 32;

    typedef struct packed {
        logic [TS_W-1:0]            ts;
        logic [`NOC_DATA_WIDTH-1:0] data;
    } trace_entry_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } trc_state_t;

    // Round-robin pick: search starts after `last` and wraps 3 -> 1.
    // req[0] is channel 1. Returns CH_NONE when nothing is requesting.
    function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] req);
        logic [1:0] cand;
        logic [1:0] pick;
        pick = CH_NONE;
        cand = last;
        for (int unsigned i = 0; i < 3; i++) begin
            cand = (cand == CH_NOC3) ? CH_NOC1 : cand + 2'd1;
            if (pick == CH_NONE && req[cand - 2'd1]) begin
                pick = cand;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/l2_dbg_trace_fifo.sv
// Per-channel capture FIFO. Read data comes directly from the storage
// registers; a push into a full FIFO is accepted when it is popped in the
// same cycle.
module l2_dbg_trace_fifo
    import l2_dbg_pkg::*;
#(
    parameter int unsigned W     = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wptr;
    logic [AW:0]  r_rptr;
    logic         w_do_push;
    logic         w_do_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_data    = r_mem[r_rptr[AW-1:0]];

    // Pointer update; the extra MSB distinguishes full from empty.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
            if (w_do_pop)  r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage write; contents are don't-care until the pointers cover them.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/l2_dbg_trace_arb.sv
// L2 debug trace arbiter: captures noc1/noc2/noc3 handshakes into
// per-channel FIFOs and drains them round-robin into one registered port.
// Optional macro L2_DBG_TRACE_TS_EN adds a 32-bit capture timestamp.
module l2_dbg_trace_arb
    import l2_dbg_pkg::*;
#(
    parameter int unsigned NOC_DATA_WIDTH = `NOC_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      trace_en,
    input  logic                      drop_clr,
    input  logic                      noc1_valid_in,
    input  logic                      noc1_ready_in,
    input  logic [NOC_DATA_WIDTH-1:0] noc1_data_in,
    input  logic                      noc2_valid_out,
    input  logic                      noc2_ready_out,
    input  logic [NOC_DATA_WIDTH-1:0] noc2_data_out,
    input  logic                      noc3_valid_in,
    input  logic                      noc3_ready_in,
    input  logic [NOC_DATA_WIDTH-1:0] noc3_data_in,
    output logic                      trace_valid,
    input  logic                      trace_ready,
    output logic [1:0]                trace_chan,
    output logic [NOC_DATA_WIDTH-1:0] trace_data,
    output logic [TS_W-1:0]           trace_ts,
    output logic [CNT_W-1:0]          drop_cnt1,
    output logic [CNT_W-1:0]          drop_cnt2,
    output logic [CNT_W-1:0]          drop_cnt3
);

`ifdef L2_DBG_TRACE_TS_EN
    localparam int unsigned ENTRY_W = TS_W + NOC_DATA_WIDTH;
    logic [TS_W-1:0] r_ts;
    logic [TS_W-1:0] r_trace_ts;
`else
    localparam int unsigned ENTRY_W = NOC_DATA_WIDTH;
`endif

    trc_state_t                r_state;
    trc_state_t                w_state_nxt;
    logic [1:0]                r_last;
    logic [1:0]                r_trace_chan;
    logic [NOC_DATA_WIDTH-1:0] r_trace_data;
    logic [CNT_W-1:0]          r_drop [3];

    logic [2:0]                w_cap;
    logic [2:0]                w_full;
    logic [2:0]                w_empty;
    logic [2:0]                w_pop;
    logic [2:0]                w_drop;
    logic [NOC_DATA_WIDTH-1:0] w_din [3];
    logic [ENTRY_W-1:0]        w_wr  [3];
    logic [ENTRY_W-1:0]        w_rd  [3];
    logic [ENTRY_W-1:0]        w_sel;
    logic [1:0]                w_grant;
    logic                      w_free;
    logic                      w_load;

    assign w_cap = {noc3_valid_in  & noc3_ready_in,
                    noc2_valid_out & noc2_ready_out,
                    noc1_valid_in  & noc1_ready_in} & {3{trace_en}};
    assign w_din[0] = noc1_data_in;
    assign w_din[1] = noc2_data_out;
    assign w_din[2] = noc3_data_in;

    assign trace_valid = (r_state == ST_HOLD);
    assign w_free      = (r_state == ST_IDLE) || trace_ready;
    assign w_grant     = rr_pick(r_last, ~w_empty);
    assign w_pop       = {w_free && (w_grant == CH_NOC3),
                          w_free && (w_grant == CH_NOC2),
                          w_free && (w_grant == CH_NOC1)};
    assign w_drop      = w_cap & w_full & ~w_pop;

    // Build FIFO write entries, prefixing the timestamp when enabled.
    always_comb begin
        for (int unsigned i = 0; i < 3; i++) begin
`ifdef L2_DBG_TRACE_TS_EN
            w_wr[i] = {r_ts, w_din[i]};
`else
            w_wr[i] = w_din[i];
`endif
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_fifo
        l2_dbg_trace_fifo #(
            .W     (ENTRY_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .i_clk   (clk),
            .i_rst   (rst),
            .i_push  (w_cap[g]),
            .i_data  (w_wr[g]),
            .i_pop   (w_pop[g]),
            .o_data  (w_rd[g]),
            .o_full  (w_full[g]),
            .o_empty (w_empty[g])
        );
    end

    // Select the head entry of the granted FIFO.
    always_comb begin
        w_sel = '0;
        case (w_grant)
            CH_NOC1: w_sel = w_rd[0];
            CH_NOC2: w_sel = w_rd[1];
            CH_NOC3: w_sel = w_rd[2];
            default: w_sel = '0;
        endcase
    end

    // Output register next state: reload whenever free and a FIFO has data.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        if (w_free) begin
            if (w_grant != CH_NONE) begin
                w_state_nxt = ST_HOLD;
                w_load      = 1'b1;
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end
    end

    // Output register state, round-robin pointer and trace payload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last       <= CH_NOC3;
            r_trace_chan <= '0;
            r_trace_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_last       <= w_grant;
                r_trace_chan <= w_grant;
                r_trace_data <= w_sel[NOC_DATA_WIDTH-1:0];
            end
        end
    end

    // Saturating drop counters; clear wins over a same-cycle drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 3; i++) r_drop[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (drop_clr) begin
                    r_drop[i] <= '0;
                end else if (w_drop[i] && (r_drop[i] != '1)) begin
                    r_drop[i] <= r_drop[i] + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

`ifdef L2_DBG_TRACE_TS_EN
    // Free-running cycle counter and the timestamp half of the output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ts       <= '0;
            r_trace_ts <= '0;
        end else begin
            r_ts <= r_ts + 32'd1;
            if (w_load) r_trace_ts <= w_sel[ENTRY_W-1 -: TS_W];
        end
    end
    assign trace_ts = r_trace_ts;
`else
    assign trace_ts = '0;
`endif

    assign trace_chan = r_trace_chan;
    assign trace_data = r_trace_data;
    assign drop_cnt1  = r_drop[0];
    assign drop_cnt2  = r_drop[1];
    assign drop_cnt3  = r_drop[2];

endmodule

// File: tb/tb_l2_dbg_trace_arb.sv
// Directed self-checking bench for l2_dbg_trace_arb (FIFO_DEPTH=4, CNT_W=4).
// Honours L2_DBG_TRACE_TS_EN when expecting trace_ts.
module tb_l2_dbg_trace_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trace_en = 1'b0;
    logic        drop_clr = 1'b0;
    logic        noc1_valid_in = 1'b0, noc1_ready_in = 1'b0;
    logic [63:0] noc1_data_in = '0;
    logic        noc2_valid_out = 1'b0, noc2_ready_out = 1'b0;
    logic [63:0] noc2_data_out = '0;
    logic        noc3_valid_in = 1'b0, noc3_ready_in = 1'b0;
    logic [63:0] noc3_data_in = '0;
    logic        trace_valid;
    logic        trace_ready = 1'b0;
    logic [1:0]  trace_chan;
    logic [63:0] trace_data;
    logic [31:0] trace_ts;
    logic [3:0]  drop_cnt1, drop_cnt2, drop_cnt3;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;
    logic [31:0] tb_cyc;
    logic [31:0] exp_ts0;

    l2_dbg_trace_arb #(
        .NOC_DATA_WIDTH (64),
        .FIFO_DEPTH     (4),
        .CNT_W          (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .trace_en       (trace_en),
        .drop_clr       (drop_clr),
        .noc1_valid_in  (noc1_valid_in),
        .noc1_ready_in  (noc1_ready_in),
        .noc1_data_in   (noc1_data_in),
        .noc2_valid_out (noc2_valid_out),
        .noc2_ready_out (noc2_ready_out),
        .noc2_data_out  (noc2_data_out),
        .noc3_valid_in  (noc3_valid_in),
        .noc3_ready_in  (noc3_ready_in),
        .noc3_data_in   (noc3_data_in),
        .trace_valid    (trace_valid),
        .trace_ready    (trace_ready),
        .trace_chan     (trace_chan),
        .trace_data     (trace_data),
        .trace_ts       (trace_ts),
        .drop_cnt1      (drop_cnt1),
        .drop_cnt2      (drop_cnt2),
        .drop_cnt3      (drop_cnt3)
    );

    always #5 clk = ~clk;

    // Reference cycle counter: 0 after reset, +1 per edge.
    always @(posedge clk or posedge rst) begin
        if (rst) tb_cyc <= '0;
        else     tb_cyc <= tb_cyc + 32'd1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_caps();
        noc1_valid_in = 1'b0; noc1_ready_in = 1'b0;
        noc2_valid_out = 1'b0; noc2_ready_out = 1'b0;
        noc3_valid_in = 1'b0; noc3_ready_in = 1'b0;
    endtask

    task automatic cap(input int unsigned ch, input logic [63:0] d);
        case (ch)
            1: begin noc1_valid_in = 1'b1; noc1_ready_in = 1'b1; noc1_data_in = d; end
            2: begin noc2_valid_out = 1'b1; noc2_ready_out = 1'b1; noc2_data_out = d; end
            default: begin noc3_valid_in = 1'b1; noc3_ready_in = 1'b1; noc3_data_in = d; end
        endcase
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [31:0] ts_exp(input logic [31:0] cyc);
`ifdef L2_DBG_TRACE_TS_EN
        return cyc;
`else
        return 32'd0 & cyc;
`endif
    endfunction

    initial begin
        clr_caps();
        do_reset();

        // Reset values.
        chk("rst_valid", trace_valid, 0);
        chk("rst_chan",  trace_chan, 0);
        chk("rst_data",  trace_data, 0);
        chk("rst_ts",    trace_ts, 0);
        chk("rst_drop1", drop_cnt1, 0);
        chk("rst_drop2", drop_cnt2, 0);
        chk("rst_drop3", drop_cnt3, 0);

        // Single noc2 capture: valid two cycles later.
        trace_en = 1'b1;
        trace_ready = 1'b1;
        repeat (3) step();
        cap(2, 64'hA5A5);
        exp_ts0 = ts_exp(tb_cyc);
        step();
        clr_caps();
        chk("single_lat1_valid", trace_valid, 0);
        step();
        chk("single_valid", trace_valid, 1);
        chk("single_chan",  trace_chan, 2);
        chk("single_data",  trace_data, 64'hA5A5);
        chk("single_ts",    trace_ts, exp_ts0);
        step();
        chk("single_drain", trace_valid, 0);

        // trace_en low: handshake ignored.
        trace_en = 1'b0;
        cap(1, 64'hDEAD);
        step();
        clr_caps();
        step();
        chk("en_low_nocap", trace_valid, 0);
        trace_en = 1'b1;

        // Round-robin: all three channels capture twice.
        do_reset();
        cap(1, 64'h11); cap(2, 64'h21); cap(3, 64'h31);
        step();
        cap(1, 64'h12); cap(2, 64'h22); cap(3, 64'h32);
        step();
        clr_caps();
        for (int unsigned i = 0; i < 6; i++) begin
            chk("rr_valid", trace_valid, 1);
            chk("rr_chan",  trace_chan, (i % 3) + 1);
            chk("rr_data",  trace_data, 64'h11 + 64'h10 * (i % 3) + (i / 3));
            step();
        end
        chk("rr_end", trace_valid, 0);

        // Overflow plus backpressure stability.
        do_reset();
        trace_ready = 1'b0;
        cap(1, 64'h100);
        exp_ts0 = ts_exp(tb_cyc);
        step();
        clr_caps();
        step();
        for (int unsigned i = 0; i < 8; i++) begin
            clr_caps();
            if (i < 6) cap(1, 64'h101 + 64'(i));
            chk("bp_valid", trace_valid, 1);
            chk("bp_chan",  trace_chan, 1);
            chk("bp_data",  trace_data, 64'h100);
            chk("bp_ts",    trace_ts, exp_ts0);
            step();
        end
        clr_caps();
        chk("ovf_drop1", drop_cnt1, 2);
        chk("ovf_drop2", drop_cnt2, 0);
        trace_ready = 1'b1;
        for (int unsigned i = 0; i < 5; i++) begin
            chk("ovf_valid", trace_valid, 1);
            chk("ovf_data",  trace_data, 64'h100 + 64'(i));
            step();
        end
        chk("ovf_end", trace_valid, 0);

        // Drop counter saturation and clear priority on noc3.
        do_reset();
        trace_ready = 1'b0;
        cap(3, 64'h300);
        repeat (19) step();
        chk("sat_drop3_14", drop_cnt3, 14);
        repeat (6) step();
        chk("sat_drop3_15", drop_cnt3, 15);
        drop_clr = 1'b1;
        step();
        drop_clr = 1'b0;
        chk("clr_prio", drop_cnt3, 0);
        step();
        chk("clr_then_drop", drop_cnt3, 1);
        clr_caps();
        step();
        chk("hold_drop", drop_cnt3, 1);

        // Mid-run reset with queued entries.
        chk("mr_pre_valid", trace_valid, 1);
        #3;
        rst = 1'b1;
        #1;
        chk("mr_async_valid", trace_valid, 0);
        chk("mr_async_drop3", drop_cnt3, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        trace_ready = 1'b1;
        for (int unsigned i = 0; i < 6; i++) begin
            step();
            chk("mr_no_emit", trace_valid, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
